// File: rtl/hwag_ch_sched.sv
// Crank-angle channel scheduler.
// Four output channels are each driven inside an angle window [on, off) that may
// wrap through angle 0. Software writes shadow registers; the shadows are copied
// into the active set every cycle while idle and only at the revolution wrap
// while synchronised, so a window never changes in the middle of a revolution.
//
// Configuration handshake: wr_en is a single-cycle strobe with no back-pressure
// (the block is always ready). Every cycle with wr_en high produces exactly one
// response pulse on the following cycle: wr_ack if the shadow register was
// written, wr_err if the address is reserved or an angle value exceeds
// ANGLE_MAX (nothing is written in that case). Writes may arrive every cycle.
module hwag_ch_sched #(
  parameter logic [11:0] ANGLE_MAX = 12'd3839
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hwag_start,
  input  logic [11:0] angle,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [11:0] wr_data,
  output logic        wr_ack,
  output logic        wr_err,
  output logic [3:0]  ch_out,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [11:0] angle_q;
  logic        start_q;

  logic [3:0][11:0] sh_on;
  logic [3:0][11:0] sh_off;
  logic [3:0][11:0] ac_on;
  logic [3:0][11:0] ac_off;
  logic [3:0]       sh_en;
  logic [3:0]       ac_en;

  logic [3:0][11:0] eff_on;
  logic [3:0][11:0] eff_off;
  logic [3:0]       eff_en;
  logic [3:0]       win;
  logic [3:0]       ch_d;

  logic wrap;
  logic commit;
  logic addr_angle;
  logic addr_mask;
  logic wr_ok;
  logic wr_bad;

  // Wrap only counts when the angle stream was valid on both sides of the drop.
  assign wrap   = hwag_start & start_q & (angle < angle_q);
  assign commit = (state_q == ST_IDLE) | wrap;

  // Write decode: 0-7 are angle registers (range-checked), 8 is the enable mask.
  assign addr_angle = (wr_addr < 4'd8);
  assign addr_mask  = (wr_addr == 4'd8);
  assign wr_ok      = wr_en & ((addr_angle & (wr_data <= ANGLE_MAX)) | addr_mask);
  assign wr_bad     = wr_en & ~wr_ok;

  // On a commit cycle the window is judged against the values being committed,
  // i.e. the pre-write shadow contents.
  assign eff_on  = commit ? sh_on  : ac_on;
  assign eff_off = commit ? sh_off : ac_off;
  assign eff_en  = commit ? sh_en  : ac_en;

  assign state = state_q;

  // Angle history used for wrap and start-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      angle_q <= '0;
      start_q <= 1'b0;
    end else begin
      angle_q <= angle;
      start_q <= hwag_start;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: lock on start edge, run from the first wrap, drop on loss.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (hwag_start && !start_q) state_d = ST_SYNC;
      end
      ST_SYNC: begin
        if (!hwag_start)  state_d = ST_IDLE;
        else if (wrap)    state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!hwag_start)  state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Shadow register writes and the one-cycle response pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sh_on  <= '0;
      sh_off <= '0;
      sh_en  <= '0;
      wr_ack <= 1'b0;
      wr_err <= 1'b0;
    end else begin
      wr_ack <= wr_ok;
      wr_err <= wr_bad;
      if (wr_ok) begin
        if (addr_mask)       sh_en <= wr_data[3:0];
        else if (wr_addr[2]) sh_off[wr_addr[1:0]] <= wr_data;
        else                 sh_on[wr_addr[1:0]]  <= wr_data;
      end
    end
  end

  // Shadow-to-active copy: continuous while idle, at the wrap otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ac_on  <= '0;
      ac_off <= '0;
      ac_en  <= '0;
    end else if (commit) begin
      ac_on  <= sh_on;
      ac_off <= sh_off;
      ac_en  <= sh_en;
    end
  end

  // Per-channel window test; equal on/off means the channel never fires.
  always_comb begin
    win = '0;
    for (int i = 0; i < 4; i++) begin
      if (eff_on[i] < eff_off[i]) begin
        win[i] = (angle >= eff_on[i]) && (angle < eff_off[i]);
      end else if (eff_on[i] > eff_off[i]) begin
        win[i] = (angle >= eff_on[i]) || (angle < eff_off[i]);
      end
    end
  end

  // Gate with the state being entered so outputs never lead or lag the state.
  assign ch_d = (state_d == ST_RUN) ? (eff_en & win) : 4'b0000;

  // Registered channel outputs, one clock behind the angle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_out <= 4'b0000;
    end else begin
      ch_out <= ch_d;
    end
  end

endmodule

// File: tb/tb_hwag_ch_sched.sv
// Testbench for hwag_ch_sched: register-write vector table, directed revolution
// sweeps, randomized traffic against a behavioural model, and async reset.
module tb_hwag_ch_sched;

  localparam int AMAX = 3839;
  localparam int NANG = AMAX + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        hwag_start = 1'b0;
  logic [11:0] angle = '0;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [11:0] wr_data = '0;
  logic        wr_ack;
  logic        wr_err;
  logic [3:0]  ch_out;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected {ch_out, state, wr_ack, wr_err} per clock.
  logic [7:0] exp_q[$];

  // Behavioural model: 0 idle, 1 sync, 2 run.
  int       m_state;
  int       m_prev_angle;
  bit       m_prev_start;
  int       m_sh_on[4];
  int       m_sh_off[4];
  int       m_ac_on[4];
  int       m_ac_off[4];
  bit [3:0] m_sh_en;
  bit [3:0] m_ac_en;

  typedef struct packed {
    logic [3:0]  addr;
    logic [11:0] data;
    logic        ack;
    logic        err;
  } wr_vec_t;

  wr_vec_t vecs[12];

  hwag_ch_sched #(.ANGLE_MAX(12'd3839)) dut (
    .clk        (clk),
    .rst        (rst),
    .hwag_start (hwag_start),
    .angle      (angle),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ack     (wr_ack),
    .wr_err     (wr_err),
    .ch_out     (ch_out),
    .state      (state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Angle a lies in [on, off) measured forward around the circle.
  function automatic bit in_win(input int a, input int on, input int off);
    return ((a - on + NANG) % NANG) < ((off - on + NANG) % NANG);
  endfunction

  function automatic void model_reset();
    m_state = 0;
    m_prev_angle = 0;
    m_prev_start = 0;
    for (int i = 0; i < 4; i++) begin
      m_sh_on[i] = 0; m_sh_off[i] = 0; m_ac_on[i] = 0; m_ac_off[i] = 0;
    end
    m_sh_en = '0;
    m_ac_en = '0;
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  function automatic void model_clock();
    int       a;
    int       nxt;
    bit       wrap;
    bit       commit;
    bit       ack;
    bit       err;
    bit [3:0] ch;
    int       eon[4];
    int       eoff[4];
    bit [3:0] een;
    int       adr;
    int       dat;
    a = int'(angle);
    wrap = hwag_start && m_prev_start && (a < m_prev_angle);
    commit = (m_state == 0) || wrap;
    nxt = m_state;
    if (m_state == 0) begin
      if (hwag_start && !m_prev_start) nxt = 1;
    end else if (!hwag_start) begin
      nxt = 0;
    end else if (wrap) begin
      nxt = 2;
    end
    for (int i = 0; i < 4; i++) begin
      eon[i]  = commit ? m_sh_on[i]  : m_ac_on[i];
      eoff[i] = commit ? m_sh_off[i] : m_ac_off[i];
    end
    een = commit ? m_sh_en : m_ac_en;
    ch = '0;
    if (nxt == 2) begin
      for (int i = 0; i < 4; i++) ch[i] = een[i] && in_win(a, eon[i], eoff[i]);
    end
    ack = 0;
    err = 0;
    adr = int'(wr_addr);
    dat = int'(wr_data);
    if (commit) begin
      m_ac_on = m_sh_on;
      m_ac_off = m_sh_off;
      m_ac_en = m_sh_en;
    end
    if (wr_en) begin
      if (adr < 4 && dat <= AMAX)      begin ack = 1; m_sh_on[adr] = dat; end
      else if (adr < 8 && dat <= AMAX) begin ack = 1; m_sh_off[adr - 4] = dat; end
      else if (adr == 8)               begin ack = 1; m_sh_en = wr_data[3:0]; end
      else                             err = 1;
    end
    exp_q.push_back({ch, 2'(nxt), ack, err});
    m_state = nxt;
    m_prev_angle = a;
    m_prev_start = hwag_start;
  endfunction

  // One clock: model step, edge, then scoreboard compare away from the edge.
  task automatic tick();
    logic [7:0] e;
    model_clock();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("ch_out", ch_out, e[7:4]);
    check("state", state, e[3:2]);
    check("wr_resp", {wr_ack, wr_err}, e[1:0]);
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [11:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    tick();
    check("write_ack", wr_ack, 1);
    wr_en = 1'b0;
  endtask

  task automatic set_angle_tick(input int a);
    angle = 12'(a);
    tick();
  endtask

  initial begin
    int c0;
    int c1;
    int cnz;
    int csync;
    int cur;
    int low_cnt;

    vecs[0]  = '{4'd0,  12'd3840, 1'b0, 1'b1};
    vecs[1]  = '{4'd1,  12'd3839, 1'b1, 1'b0};
    vecs[2]  = '{4'd8,  12'hFFF,  1'b1, 1'b0};
    vecs[3]  = '{4'd9,  12'd5,    1'b0, 1'b1};
    vecs[4]  = '{4'd15, 12'd0,    1'b0, 1'b1};
    vecs[5]  = '{4'd0,  12'd100,  1'b1, 1'b0};
    vecs[6]  = '{4'd4,  12'd200,  1'b1, 1'b0};
    vecs[7]  = '{4'd1,  12'd3800, 1'b1, 1'b0};
    vecs[8]  = '{4'd5,  12'd40,   1'b1, 1'b0};
    vecs[9]  = '{4'd8,  12'd3,    1'b1, 1'b0};
    vecs[10] = '{4'd4,  12'd4000, 1'b0, 1'b1};
    vecs[11] = '{4'd12, 12'd7,    1'b0, 1'b1};

    // Reset.
    model_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ch_out", ch_out, 0);
    check("reset_state", state, 0);
    check("reset_ack", wr_ack, 0);
    check("reset_err", wr_err, 0);
    rst = 1'b1;
    tick();

    // Back-to-back configuration writes from the vector table.
    for (int i = 0; i < 12; i++) begin
      wr_en = 1'b1; wr_addr = vecs[i].addr; wr_data = vecs[i].data;
      tick();
      check("tbl_ack", wr_ack, vecs[i].ack);
      check("tbl_err", wr_err, vecs[i].err);
    end
    wr_en = 1'b0;
    tick();
    tick();

    // Revolution 1: locked but not yet synchronised, no output.
    hwag_start = 1'b1;
    csync = 0; cnz = 0;
    for (int a = 0; a < NANG; a++) begin
      set_angle_tick(a);
      if (state == 2'd1) csync++;
      if (ch_out != 0) cnz++;
    end
    check("rev1_sync_cycles", csync, NANG);
    check("rev1_no_output", cnz, 0);

    // Revolution 2: running, ch0 100..199 and ch1 3800..39.
    c0 = 0; c1 = 0;
    for (int a = 0; a < NANG; a++) begin
      set_angle_tick(a);
      if (a == 0)   check("wrap_to_run", state, 2);
      if (a == 0)   check("ch1_at_wrap", ch_out[1], 1);
      if (a == 100) check("ch0_on_edge", ch_out[0], 1);
      if (a == 200) check("ch0_off_edge", ch_out[0], 0);
      c0 += ch_out[0];
      c1 += ch_out[1];
    end
    check("rev2_ch0_cycles", c0, 100);
    check("rev2_ch1_cycles", c1, 80);

    // Revolution 3: move ch0 off to 300 mid-window; takes effect next revolution.
    c0 = 0;
    for (int a = 0; a < NANG; a++) begin
      wr_en = (a == 150); wr_addr = 4'd4; wr_data = 12'd300;
      set_angle_tick(a);
      if (a == 150) check("midrev_ack", wr_ack, 1);
      if (a == 151) check("midrev_ack_pulse", wr_ack, 0);
      c0 += ch_out[0];
    end
    wr_en = 1'b0;
    check("rev3_ch0_cycles", c0, 100);

    c0 = 0;
    for (int a = 0; a < NANG; a++) begin
      set_angle_tick(a);
      c0 += ch_out[0];
    end
    check("rev4_ch0_cycles", c0, 200);

    // Drop lock mid-window, then relock: no output until the next wrap.
    for (int a = 0; a < 150; a++) set_angle_tick(a);
    check("pre_drop_ch0", ch_out[0], 1);
    hwag_start = 1'b0;
    set_angle_tick(150);
    check("drop_ch_out", ch_out, 0);
    check("drop_state", state, 0);
    tick();
    tick();
    hwag_start = 1'b1;
    cnz = 0; csync = 0;
    for (int a = 151; a < NANG; a++) begin
      set_angle_tick(a);
      if (ch_out != 0) cnz++;
      if (state == 2'd1) csync++;
    end
    check("relock_no_output", cnz, 0);
    check("relock_sync_cycles", csync, NANG - 151);
    set_angle_tick(0);
    check("relock_run", state, 2);

    // Randomized traffic against the model.
    cur = 0;
    low_cnt = 0;
    for (int n = 0; n < 6000; n++) begin
      cur = (cur + $urandom_range(0, 25)) % NANG;
      angle = 12'(cur);
      if (low_cnt > 0) begin
        low_cnt--;
        hwag_start = (low_cnt == 0);
      end else if ($urandom_range(0, 799) == 0) begin
        low_cnt = $urandom_range(1, 4);
        hwag_start = 1'b0;
      end else begin
        hwag_start = 1'b1;
      end
      if ($urandom_range(0, 15) == 0) begin
        wr_en = 1'b1;
        wr_addr = 4'($urandom_range(0, 15));
        wr_data = ($urandom_range(0, 3) == 0) ? 12'($urandom_range(0, 4095))
                                              : 12'($urandom_range(0, AMAX));
      end else begin
        wr_en = 1'b0;
      end
      tick();
    end
    wr_en = 1'b0;

    // Asynchronous reset while ch0 is mid-window in RUN.
    hwag_start = 1'b0;
    angle = '0;
    tick();
    tick();
    write_reg(4'd0, 12'd100);
    write_reg(4'd4, 12'd200);
    write_reg(4'd8, 12'd1);
    tick();
    hwag_start = 1'b1;
    for (int a = 0; a < NANG; a++) set_angle_tick(a);
    for (int a = 0; a <= 150; a++) set_angle_tick(a);
    check("prereset_ch0", ch_out[0], 1);
    #3;
    rst = 1'b0;
    #1;
    check("async_ch_out", ch_out, 0);
    check("async_state", state, 0);
    model_reset();
    @(posedge clk);
    #1;
    check("in_reset_ch_out", ch_out, 0);
    rst = 1'b1;
    cnz = 0;
    for (int r = 0; r < 2; r++) begin
      for (int a = 0; a < NANG; a++) begin
        set_angle_tick(a);
        if (ch_out != 0) cnz++;
      end
    end
    check("post_reset_no_output", cnz, 0);
    check("post_reset_run", state, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
